// File: rtl/frame_feed_if.sv
// Handshake and data bundle between the frame feeder, its controller, the
// pixel memory and the sliding-window line buffer.
interface frame_feed_if #(
   parameter int I_F_BW = 8,
   parameter int AW     = 10,
   parameter int WCW    = 10
);
   logic              i_start;
   logic              i_abort;
   logic              i_stall;
   logic              o_busy;
   logic              o_done;
   logic              o_err;
   logic              o_mem_rd_en;
   logic [AW-1:0]     o_mem_addr;
   logic [I_F_BW-1:0] i_mem_data;
   logic              o_lb_clear;
   logic              o_lb_valid;
   logic [I_F_BW-1:0] o_lb_pixel;
   logic              i_win_valid;
   logic [WCW-1:0]    o_win_cnt;

   modport slave (
      input  i_start, i_abort, i_stall, i_mem_data, i_win_valid,
      output o_busy, o_done, o_err, o_mem_rd_en, o_mem_addr,
             o_lb_clear, o_lb_valid, o_lb_pixel, o_win_cnt
   );

   modport master (
      output i_start, i_abort, i_stall, i_mem_data, i_win_valid,
      input  o_busy, o_done, o_err, o_mem_rd_en, o_mem_addr,
             o_lb_clear, o_lb_valid, o_lb_pixel, o_win_cnt
   );
endinterface

// File: rtl/frame_feed_ctrl.sv
// Streams one row-major frame from pixel memory into the conv line buffer,
// counts returned windows and reports completion or drain timeout.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for i_start; outputs quiet
//   CLEAR   | one-cycle line-buffer clear pulse
//   FEED    | one memory read per unstalled cycle, address 0..NPIX-1
//   DRAIN   | reads done; wait for pipeline empty and all windows seen
//   DONE    | one-cycle o_done pulse
module frame_feed_ctrl #(
   parameter int I_F_BW    = 8,
   parameter int IX        = 28,
   parameter int IY        = 28,
   parameter int KX        = 5,
   parameter int KY        = 5,
   parameter int MEM_LAT   = 1,
   parameter int DRAIN_MAX = 256
) (
   input logic         clk,
   input logic         reset_n,
   frame_feed_if.slave ffi
);
   localparam int NPIX    = IX * IY;
   localparam int EXP_WIN = (IX - KX + 1) * (IY - KY + 1);
   localparam int AW      = $clog2(NPIX);
   localparam int WCW     = $clog2(EXP_WIN + 1);
   localparam int DW      = $clog2(DRAIN_MAX + 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CLEAR = 3'd1;
   localparam logic [2:0] S_FEED  = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam logic [AW-1:0]  ADDR_LAST  = AW'(NPIX - 1);
   localparam logic [WCW-1:0] WIN_FULL   = WCW'(EXP_WIN);
   localparam logic [DW-1:0]  DRAIN_LOAD = DW'(DRAIN_MAX);

   logic [2:0]         state_q, state_d;
   logic [AW-1:0]      addr_q, addr_d;
   logic [WCW-1:0]     win_cnt_q, win_cnt_d;
   logic [DW-1:0]      drain_q, drain_d;
   logic               err_q, err_d;
   logic [MEM_LAT-1:0] pipe_q;
   logic               lb_valid_q;
   logic [I_F_BW-1:0]  lb_pixel_q;
   logic               rd_en;
   logic               pipe_empty;
   logic               counting;

   assign rd_en      = (state_q == S_FEED) && !ffi.i_stall;
   assign pipe_empty = (pipe_q == '0) && !lb_valid_q;
   assign counting   = (state_q == S_CLEAR) || (state_q == S_FEED) || (state_q == S_DRAIN);

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      win_cnt_d = win_cnt_q;
      drain_d   = drain_q;
      err_d     = err_q;

      if (counting && ffi.i_win_valid && (win_cnt_q != WIN_FULL)) begin
         win_cnt_d = win_cnt_q + WCW'(1);
      end

      case (state_q)
         S_IDLE: begin
            if (ffi.i_start && !ffi.i_abort) begin
               state_d   = S_CLEAR;
               err_d     = 1'b0;
               win_cnt_d = '0;
               addr_d    = '0;
            end
         end
         S_CLEAR: state_d = S_FEED;
         S_FEED: begin
            if (rd_en) begin
               if (addr_q == ADDR_LAST) begin
                  addr_d  = '0;
                  state_d = S_DRAIN;
                  drain_d = DRAIN_LOAD;
               end else begin
                  addr_d = addr_q + AW'(1);
               end
            end
         end
         S_DRAIN: begin
            // drain timer counts down from DRAIN_MAX; terminal count is the timeout
            if (pipe_empty && (win_cnt_q == WIN_FULL)) begin
               state_d = S_DONE;
            end else if (drain_q == '0) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               drain_d = drain_q - DW'(1);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (ffi.i_abort) begin
         state_d = S_IDLE;
         err_d   = err_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         win_cnt_q  <= '0;
         drain_q    <= '0;
         err_q      <= 1'b0;
         pipe_q     <= '0;
         lb_valid_q <= 1'b0;
         lb_pixel_q <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         win_cnt_q <= win_cnt_d;
         drain_q   <= drain_d;
         err_q     <= err_d;
         if (ffi.i_abort) begin
            pipe_q     <= '0;
            lb_valid_q <= 1'b0;
         end else begin
            // pipe tail lines up with memory data arriving MEM_LAT cycles after the read
            pipe_q[0] <= rd_en;
            for (int i = 1; i < MEM_LAT; i++) pipe_q[i] <= pipe_q[i-1];
            lb_valid_q <= pipe_q[MEM_LAT-1];
            if (pipe_q[MEM_LAT-1]) lb_pixel_q <= ffi.i_mem_data;
         end
      end
   end

   assign ffi.o_busy      = (state_q != S_IDLE);
   assign ffi.o_done      = (state_q == S_DONE);
   assign ffi.o_err       = err_q;
   assign ffi.o_mem_rd_en = rd_en;
   assign ffi.o_mem_addr  = addr_q;
   assign ffi.o_lb_clear  = (state_q == S_CLEAR);
   assign ffi.o_lb_valid  = lb_valid_q;
   assign ffi.o_lb_pixel  = lb_pixel_q;
   assign ffi.o_win_cnt   = win_cnt_q;
endmodule

// File: tb/tb_frame_feed_ctrl.sv
// Self-checking bench for frame_feed_ctrl: default 28x28 instance plus a 6x6
// instance, with memory and line-buffer behaviour modelled in the bench.
module tb_frame_feed_ctrl;
   localparam int IX = 28, IY = 28, KX = 5, KY = 5, MEM_LAT = 1, DRAIN_MAX = 256;
   localparam int NPIX = IX * IY;
   localparam int EXP_WIN = (IX - KX + 1) * (IY - KY + 1);
   localparam int SX = 6, SY = 6, SK = 3;
   localparam int S_NPIX = SX * SY;
   localparam int S_EXP_WIN = (SX - SK + 1) * (SY - SK + 1);

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   frame_feed_if #(.I_F_BW(8), .AW(10), .WCW(10)) A ();
   frame_feed_if #(.I_F_BW(8), .AW(6),  .WCW(5))  B ();

   frame_feed_ctrl #(.I_F_BW(8), .IX(IX), .IY(IY), .KX(KX), .KY(KY),
                     .MEM_LAT(MEM_LAT), .DRAIN_MAX(DRAIN_MAX))
      u_big (.clk(clk), .reset_n(rst_n), .ffi(A));

   frame_feed_ctrl #(.I_F_BW(8), .IX(SX), .IY(SY), .KX(SK), .KY(SK),
                     .MEM_LAT(1), .DRAIN_MAX(DRAIN_MAX))
      u_small (.clk(clk), .reset_n(rst_n), .ffi(B));

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   logic [7:0] mem [NPIX];

   // per-frame observations from the default instance
   int n_reads, n_addr_bad, n_pix_bad, n_lat_bad, n_stall_bad, n_clear, n_clear_late;
   int n_done, drain_cycles, win_sent;
   integer done_win, end_win;
   logic end_err, err_at_clear, busy_after_done, timed_out;
   logic ab_rd, ab_lbv, ab_busy, pre_busy;
   logic [33:0] rst_vec;

   task automatic idle_inputs();
      A.i_start = 0; A.i_abort = 0; A.i_stall = 0; A.i_win_valid = 0;
      B.i_start = 0; B.i_abort = 0; B.i_stall = 0; B.i_win_valid = 0;
   endtask

   // Drives one frame on the default instance and records what it saw.
   task automatic run_frame(input int stall_pct, input int win_limit, input int abort_at,
                            input int reset_at, input int start_at);
      int rd_q[$];
      logic [7:0] pix_q[$];
      int exp_addr, lbm_pix, r, c, done_cyc, abort_cyc;
      logic seen_busy, win_next, pend_v, finished;
      logic [9:0] pend_a;
      n_reads = 0; n_addr_bad = 0; n_pix_bad = 0; n_lat_bad = 0; n_stall_bad = 0;
      n_clear = 0; n_clear_late = 0; n_done = 0; drain_cycles = 0; win_sent = 0;
      done_win = -1; end_win = -1; end_err = 1'bx; err_at_clear = 1'bx;
      busy_after_done = 1'bx; timed_out = 0; ab_rd = 1'bx; ab_lbv = 1'bx; ab_busy = 1'bx;
      exp_addr = 0; lbm_pix = 0; done_cyc = -10; abort_cyc = -10;
      seen_busy = 0; win_next = 0; pend_v = 0; pend_a = '0; finished = 0;
      for (int k = 0; k < 6000; k++) begin
         @(negedge clk);
         cyc++;
         A.i_start = (k == 0) || (start_at >= 0 && n_reads == start_at);
         A.i_stall = ($urandom_range(0, 99) < stall_pct);
         A.i_abort = 0;
         if (abort_at >= 0 && n_reads == abort_at && abort_cyc < 0) begin
            A.i_abort = 1; abort_cyc = cyc;
         end
         A.i_win_valid = win_next;
         if (win_next) win_sent++;
         if (pend_v) A.i_mem_data = mem[pend_a];
         if (reset_at >= 0 && n_reads == reset_at) begin
            pre_busy = A.o_busy;
            rst_n = 0;
            #1;
            rst_vec = {A.o_busy, A.o_done, A.o_err, A.o_mem_rd_en, A.o_mem_addr,
                       A.o_lb_clear, A.o_lb_valid, A.o_lb_pixel, A.o_win_cnt};
            idle_inputs();
            @(negedge clk);
            rst_n = 1;
            finished = 1;
            break;
         end
         #1;
         if (A.o_busy) seen_busy = 1;
         if (A.o_lb_clear) begin n_clear++; lbm_pix = 0; err_at_clear = A.o_err; end
         pend_v = A.o_mem_rd_en; pend_a = A.o_mem_addr;
         if (A.o_mem_rd_en) begin
            if (A.o_mem_addr !== exp_addr[9:0]) n_addr_bad++;
            if (A.i_stall) n_stall_bad++;
            if (n_clear == 0) n_clear_late++;
            rd_q.push_back(cyc);
            pix_q.push_back(mem[A.o_mem_addr]);
            n_reads++; exp_addr++;
         end else if (A.o_busy && n_reads == NPIX) begin
            drain_cycles++;
         end
         win_next = 0;
         if (A.o_lb_valid) begin
            if (rd_q.size() == 0) n_pix_bad++;
            else begin
               if (cyc - rd_q.pop_front() != MEM_LAT + 1) n_lat_bad++;
               if (A.o_lb_pixel !== pix_q.pop_front()) n_pix_bad++;
            end
            r = lbm_pix / IX; c = lbm_pix % IX; lbm_pix++;
            win_next = (r >= KY - 1) && (c >= KX - 1) && (win_sent < win_limit);
         end
         if (A.o_done) begin n_done++; done_cyc = cyc; done_win = A.o_win_cnt; end
         if (cyc == done_cyc + 1) busy_after_done = A.o_busy;
         if (cyc == abort_cyc + 1) begin
            ab_rd = A.o_mem_rd_en; ab_lbv = A.o_lb_valid; ab_busy = A.o_busy;
            end_err = A.o_err; finished = 1;
            break;
         end
         if (seen_busy && !A.o_busy) begin
            end_err = A.o_err; end_win = A.o_win_cnt; finished = 1;
            break;
         end
      end
      if (!finished) timed_out = 1;
      idle_inputs();
   endtask

   task automatic test_reset();
      idle_inputs();
      A.i_mem_data = 0; B.i_mem_data = 0;
      rst_n = 0;
      repeat (3) @(negedge clk);
      #1;
      n_cmp++; if ({A.o_busy, A.o_done, A.o_err, A.o_mem_rd_en, A.o_lb_clear, A.o_lb_valid} !== 6'b0) begin
         n_bad++; $display("FAIL reset_flags: got %b want 000000", {A.o_busy, A.o_done, A.o_err, A.o_mem_rd_en, A.o_lb_clear, A.o_lb_valid}); end
      n_cmp++; if ({A.o_mem_addr, A.o_lb_pixel, A.o_win_cnt} !== 28'b0) begin
         n_bad++; $display("FAIL reset_data: addr=%0d pix=%0d win=%0d want 0", A.o_mem_addr, A.o_lb_pixel, A.o_win_cnt); end
      @(negedge clk); rst_n = 1;
      repeat (2) @(negedge clk);
      #1;
      n_cmp++; if ({A.o_busy, B.o_busy, A.o_mem_rd_en, B.o_mem_rd_en} !== 4'b0) begin
         n_bad++; $display("FAIL reset_release_idle: got %b want 0000", {A.o_busy, B.o_busy, A.o_mem_rd_en, B.o_mem_rd_en}); end
   endtask

   task automatic test_frame_nostall();
      run_frame(0, EXP_WIN + 10, -1, -1, -1);
      n_cmp++; if (timed_out !== 0) begin n_bad++; $display("FAIL nostall_timeout: got %b want 0", timed_out); end
      n_cmp++; if (n_reads !== NPIX) begin n_bad++; $display("FAIL nostall_reads: got %0d want %0d", n_reads, NPIX); end
      n_cmp++; if (n_addr_bad !== 0) begin n_bad++; $display("FAIL nostall_addr_order: got %0d bad want 0", n_addr_bad); end
      n_cmp++; if (n_lat_bad !== 0) begin n_bad++; $display("FAIL nostall_latency: got %0d bad want 0", n_lat_bad); end
      n_cmp++; if (n_pix_bad !== 0) begin n_bad++; $display("FAIL nostall_pixels: got %0d bad want 0", n_pix_bad); end
      n_cmp++; if (n_clear !== 1 || n_clear_late !== 0) begin
         n_bad++; $display("FAIL nostall_clear: got %0d pulses, %0d reads before clear, want 1 and 0", n_clear, n_clear_late); end
      n_cmp++; if (n_done !== 1) begin n_bad++; $display("FAIL nostall_done: got %0d want 1", n_done); end
      n_cmp++; if (done_win !== EXP_WIN) begin n_bad++; $display("FAIL nostall_win_cnt: got %0d want %0d", done_win, EXP_WIN); end
      n_cmp++; if (busy_after_done !== 0) begin n_bad++; $display("FAIL nostall_busy_fall: got %b want 0", busy_after_done); end
      n_cmp++; if (end_win !== EXP_WIN) begin n_bad++; $display("FAIL nostall_win_hold: got %0d want %0d", end_win, EXP_WIN); end
   endtask

   task automatic test_frame_random_stall();
      run_frame(35, EXP_WIN + 10, -1, -1, -1);
      n_cmp++; if (n_reads !== NPIX || n_addr_bad !== 0) begin
         n_bad++; $display("FAIL stall_reads: got %0d reads %0d bad want %0d 0", n_reads, n_addr_bad, NPIX); end
      n_cmp++; if (n_stall_bad !== 0) begin n_bad++; $display("FAIL stall_read_while_stalled: got %0d want 0", n_stall_bad); end
      n_cmp++; if (n_lat_bad !== 0 || n_pix_bad !== 0) begin
         n_bad++; $display("FAIL stall_pipeline: got lat=%0d pix=%0d bad want 0 0", n_lat_bad, n_pix_bad); end
      n_cmp++; if (n_done !== 1 || done_win !== EXP_WIN) begin
         n_bad++; $display("FAIL stall_done: got %0d pulses win %0d want 1 %0d", n_done, done_win, EXP_WIN); end
   endtask

   task automatic test_small_stall();
      int exp_a, nrd, nlbv, nbad_a, nbad_p, nbad_s, nclr, ndone, widx, feed_idx, r, c;
      integer donew;
      logic in_feed, wnext, pv, seen, fin;
      logic [5:0] pa;
      exp_a = 0; nrd = 0; nlbv = 0; nbad_a = 0; nbad_p = 0; nbad_s = 0; nclr = 0;
      ndone = 0; widx = 0; feed_idx = 0; donew = -1;
      in_feed = 0; wnext = 0; pv = 0; seen = 0; fin = 0; pa = '0;
      for (int k = 0; k < 600; k++) begin
         @(negedge clk);
         B.i_start = (k == 0);
         B.i_stall = in_feed && (feed_idx % 3 == 2);
         if (in_feed) feed_idx++;
         B.i_win_valid = wnext;
         if (pv) B.i_mem_data = 8'(pa);
         #1;
         if (B.o_busy) seen = 1;
         if (B.o_lb_clear) begin nclr++; in_feed = 1; widx = 0; end
         pv = B.o_mem_rd_en; pa = B.o_mem_addr;
         if (B.o_mem_rd_en) begin
            if (B.o_mem_addr !== exp_a[5:0]) nbad_a++;
            if (B.i_stall) nbad_s++;
            exp_a++; nrd++;
         end
         wnext = 0;
         if (B.o_lb_valid) begin
            if (B.o_lb_pixel !== nlbv[7:0]) nbad_p++;
            nlbv++;
            r = widx / SX; c = widx % SX; widx++;
            wnext = (r >= SK - 1) && (c >= SK - 1);
         end
         if (B.o_done) begin ndone++; donew = B.o_win_cnt; end
         if (seen && !B.o_busy) begin fin = 1; break; end
      end
      idle_inputs();
      n_cmp++; if (fin !== 1) begin n_bad++; $display("FAIL small_timeout: frame did not finish (got %b want 1)", fin); end
      n_cmp++; if (nrd !== S_NPIX || nbad_a !== 0) begin
         n_bad++; $display("FAIL small_reads: got %0d reads %0d addr errors want %0d 0", nrd, nbad_a, S_NPIX); end
      n_cmp++; if (nbad_s !== 0) begin n_bad++; $display("FAIL small_stall_read: got %0d want 0", nbad_s); end
      n_cmp++; if (nlbv !== S_NPIX || nbad_p !== 0) begin
         n_bad++; $display("FAIL small_pixel_order: got %0d pixels %0d wrong want %0d 0", nlbv, nbad_p, S_NPIX); end
      n_cmp++; if (ndone !== 1 || donew !== S_EXP_WIN || nclr !== 1) begin
         n_bad++; $display("FAIL small_done: got done=%0d win=%0d clr=%0d want 1 %0d 1", ndone, donew, nclr, S_EXP_WIN); end
   endtask

   task automatic test_drain_timeout();
      run_frame(0, 10, -1, -1, -1);
      n_cmp++; if (timed_out !== 0) begin n_bad++; $display("FAIL timeout_frame_end: got %b want 0", timed_out); end
      n_cmp++; if (n_done !== 0) begin n_bad++; $display("FAIL timeout_no_done: got %0d want 0", n_done); end
      n_cmp++; if (end_err !== 1) begin n_bad++; $display("FAIL timeout_err: got %b want 1", end_err); end
      n_cmp++; if (drain_cycles !== DRAIN_MAX + 1) begin
         n_bad++; $display("FAIL timeout_drain_len: got %0d want %0d", drain_cycles, DRAIN_MAX + 1); end
      n_cmp++; if (end_win !== 10) begin n_bad++; $display("FAIL timeout_win_cnt: got %0d want 10", end_win); end
   endtask

   task automatic test_start_abort_idle();
      @(negedge clk);
      A.i_start = 1; A.i_abort = 1;
      @(negedge clk);
      A.i_start = 0; A.i_abort = 0;
      #1;
      n_cmp++; if ({A.o_busy, A.o_lb_clear} !== 2'b00) begin
         n_bad++; $display("FAIL start_abort_idle: got busy,clear=%b want 00", {A.o_busy, A.o_lb_clear}); end
      n_cmp++; if (A.o_err !== 1) begin n_bad++; $display("FAIL start_abort_err_kept: got %b want 1", A.o_err); end
      repeat (3) @(negedge clk);
      #1;
      n_cmp++; if (A.o_busy !== 0) begin n_bad++; $display("FAIL start_abort_stays_idle: got %b want 0", A.o_busy); end
   endtask

   task automatic test_abort_restart();
      run_frame(0, EXP_WIN + 10, 100, -1, -1);
      n_cmp++; if (err_at_clear !== 0) begin n_bad++; $display("FAIL start_clears_err: got %b want 0", err_at_clear); end
      n_cmp++; if (n_reads !== 101 || n_addr_bad !== 0) begin
         n_bad++; $display("FAIL abort_reads: got %0d reads %0d bad want 101 0", n_reads, n_addr_bad); end
      n_cmp++; if ({ab_rd, ab_lbv, ab_busy} !== 3'b000) begin
         n_bad++; $display("FAIL abort_next_cycle: got rd,lbv,busy=%b want 000", {ab_rd, ab_lbv, ab_busy}); end
      n_cmp++; if (n_done !== 0 || end_err !== 0) begin
         n_bad++; $display("FAIL abort_no_done: got done=%0d err=%b want 0 0", n_done, end_err); end
      run_frame(0, EXP_WIN + 10, -1, -1, -1);
      n_cmp++; if (n_clear !== 1 || n_addr_bad !== 0 || n_reads !== NPIX) begin
         n_bad++; $display("FAIL abort_restart: got clr=%0d bad=%0d reads=%0d want 1 0 %0d", n_clear, n_addr_bad, n_reads, NPIX); end
      n_cmp++; if (n_done !== 1 || done_win !== EXP_WIN) begin
         n_bad++; $display("FAIL abort_restart_done: got %0d win %0d want 1 %0d", n_done, done_win, EXP_WIN); end
   endtask

   task automatic test_start_in_feed();
      run_frame(0, EXP_WIN + 10, -1, -1, 300);
      n_cmp++; if (n_clear !== 1 || n_reads !== NPIX || n_addr_bad !== 0) begin
         n_bad++; $display("FAIL start_in_feed: got clr=%0d reads=%0d bad=%0d want 1 %0d 0", n_clear, n_reads, n_addr_bad, NPIX); end
      n_cmp++; if (n_done !== 1 || done_win !== EXP_WIN) begin
         n_bad++; $display("FAIL start_in_feed_done: got %0d win %0d want 1 %0d", n_done, done_win, EXP_WIN); end
   endtask

   task automatic test_reset_mid_frame();
      run_frame(0, EXP_WIN + 10, -1, 400, -1);
      n_cmp++; if (pre_busy !== 1) begin n_bad++; $display("FAIL reset_mid_busy_before: got %b want 1", pre_busy); end
      n_cmp++; if (rst_vec !== 34'b0) begin n_bad++; $display("FAIL reset_mid_outputs: got %h want 0", rst_vec); end
      run_frame(0, EXP_WIN + 10, -1, -1, -1);
      n_cmp++; if (n_reads !== NPIX || n_addr_bad !== 0 || n_pix_bad !== 0) begin
         n_bad++; $display("FAIL reset_mid_restart: got reads=%0d addr=%0d pix=%0d want %0d 0 0", n_reads, n_addr_bad, n_pix_bad, NPIX); end
      n_cmp++; if (n_done !== 1 || done_win !== EXP_WIN) begin
         n_bad++; $display("FAIL reset_mid_done: got %0d win %0d want 1 %0d", n_done, done_win, EXP_WIN); end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom);
      test_reset();
      test_frame_nostall();
      test_frame_random_stall();
      test_small_stall();
      test_drain_timeout();
      test_start_abort_idle();
      test_abort_restart();
      test_start_in_feed();
      test_reset_mid_frame();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
